// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS encodings, ALU codes and multicycle state type
package mips_pkg;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Multicycle control states; 12..15 are unused encodings
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } mc_state_t;

  // Main-control to ALU-decoder operation class
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

endpackage

// File: rtl/aludec.sv
// rtl/aludec.sv - ALU decoder, ALUOp and funct to alucontrol
module aludec
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Unknown funct codes and the reserved ALUOp fall back to add
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS control FSM with ALU decoder
module multicycle_controller
  import mips_pkg::*;
#(
  parameter bit RESET_STATE_DBG = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] alucontrol,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  mc_state_t state_q, state_d;
  mc_state_t dec_state;
  aluop_t    aluop;
  logic      pc_write, branch;
  logic      ir_write_raw, mem_write_raw, reg_write_raw, done_raw, illegal_raw;

  // State register; reset forces FETCH even mid-instruction
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state selection; an undefined opcode in DECODE returns to FETCH and flags it
  always_comb begin
    state_d     = S_FETCH;
    illegal_raw = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // While reset is held the datapath sees the FETCH decode
  assign dec_state = reset ? S_FETCH : state_q;

  // Moore output decode; anything not set in a state stays 0
  always_comb begin
    IorD          = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    reg_write_raw = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    aluop         = ALUOP_ADD;
    PCSrc         = 2'b00;
    pc_write      = 1'b0;
    branch        = 1'b0;
    done_raw      = 1'b0;
    case (dec_state)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        ALUSrcB      = 2'b01;
        pc_write     = 1'b1;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        MemtoReg      = 1'b1;
        done_raw      = 1'b1;
      end
      S_MEMWR: begin
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst        = 1'b1;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        aluop    = ALUOP_SUB;
        PCSrc    = 2'b01;
        branch   = 1'b1;
        done_raw = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
        done_raw = 1'b1;
      end
      default: ;
    endcase
  end

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  // Enables and pulses are suppressed during reset so nothing commits
  assign PCEn       = ~reset & (pc_write | (branch & Zero));
  assign IRWrite    = ~reset & ir_write_raw;
  assign MemWrite   = ~reset & mem_write_raw;
  assign RegWrite   = ~reset & reg_write_raw;
  assign instr_done = ~reset & done_raw;
  assign illegal_op = ~reset & illegal_raw;
  assign state_dbg  = RESET_STATE_DBG ? dec_state : 4'd0;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle MIPS control FSM. It sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback steps, one step per clock.
- It replaces the single-cycle combinational control unit when the core is refactored to a multicycle datapath.
- It drives every mux select and write enable in the datapath, and contains the ALU decoder.
- Instruction set: lw, sw, R-type (add, sub, and, or, slt), beq, addi, j.

Parameters:
- RESET_STATE_DBG, 1, when 1 the `state_dbg` port carries the live state encoding; when 0 `state_dbg` is tied to 0.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- opcode  input  6  instr[31:26], read from the instruction register
- funct  input  6  instr[5:0], read from the instruction register
- Zero  input  1  ALU zero flag
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  memory write enable
- IRWrite  output  1  instruction register load enable
- RegDst  output  1  register write address select: 0 = rt, 1 = rd
- MemtoReg  output  1  register write data select: 0 = ALUOut, 1 = MDR
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALU A operand select: 0 = PC, 1 = register A
- ALUSrcB  output  2  ALU B operand select: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- alucontrol  output  3  ALU operation code
- PCSrc  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  output  1  PC register load enable
- instr_done  output  1  one-cycle pulse in the last state of each instruction
- illegal_op  output  1  one-cycle pulse when an undefined opcode is decoded
- state_dbg  output  4  current state encoding

Behaviour:
- State register is updated on the rising edge of `clk`. If `reset` = 1 at an edge, state becomes FETCH regardless of the current state, including mid-instruction.
- While `reset` = 1, these outputs are forced to 0: `PCEn`, `IRWrite`, `MemWrite`, `RegWrite`, `instr_done`, `illegal_op`. All other outputs follow the FETCH decode.
- All outputs are Moore outputs decoded from the state, except `PCEn`. `PCEn` = PCWrite | (Branch & Zero), where PCWrite and Branch are internal state decodes.
- Any signal not listed as asserted in a state is 0 in that state.
- States and encodings; per-state outputs; transitions:
  - FETCH(0): IRWrite, ALUSrcB=01, ALUOp=00, PCSrc=00, PCWrite. Next: DECODE.
  - DECODE(1): ALUSrcB=11, ALUOp=00. Next by opcode:
    - 100011 or 101011 -> MEMADR
    - 000000 -> EXECUTE
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - any other opcode -> FETCH, with `illegal_op`=1 for this cycle
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD(3): IorD=1. Next: MEMWB.
  - MEMWB(4): RegWrite, MemtoReg=1, RegDst=0, instr_done. Next: FETCH.
  - MEMWR(5): IorD=1, MemWrite, instr_done. Next: FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - ALUWB(7): RegDst=1, RegWrite, instr_done. Next: FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch, instr_done. Next: FETCH.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
  - ADDIWB(10): RegWrite, RegDst=0, instr_done. Next: FETCH.
  - JUMP(11): PCSrc=10, PCWrite, instr_done. Next: FETCH.
  - Encodings 12–15 are unreachable. If entered, outputs are all 0 and the next state is FETCH.
- Instruction latency in cycles, counted from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- ALU decoder (combinational), ALUOp to alucontrol:
  - ALUOp 00 -> 010 (add)
  - ALUOp 01 -> 110 (sub)
  - ALUOp 10, decoded by funct:
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 101010 -> 111
    - any other funct -> 010
  - ALUOp 11 -> 010
- `Zero` is sampled only in BRANCH. Its value in all other states has no effect.

Decomposition:
- Package `mips_pkg` holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants: F_ADD, F_SUB, F_AND, F_OR, F_SLT
  - alucontrol codes: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT
  - the 4-bit state enum `mc_state_t`
  - `aluop_t`
- One sub-module, `aludec`: combinational, ALUOp plus funct in, alucontrol out. It is shared with the single-cycle control unit.

Test Plan:
- Reset, then release: hold `reset`=1 for 2 edges. Required: `state_dbg`=0 and `PCEn`=`IRWrite`=`RegWrite`=`MemWrite`=0 while reset is held. On the first cycle after release: `IRWrite`=1, `PCEn`=1, `ALUSrcB`=01, `alucontrol`=010.
- lw: opcode=100011. Required state sequence 0,1,2,3,4,0. In MEMRD: `IorD`=1. In MEMWB: `RegWrite`=1, `MemtoReg`=1, `instr_done`=1. Then sw (101011): sequence 0,1,2,5,0, with `MemWrite`=1 only in state 5.
- R-type: opcode=0 with funct=100010, 100100, 100101, 101010 in turn. Required `alucontrol` in EXECUTE: 110, 000, 001, 111 respectively. In ALUWB: `RegDst`=1, `RegWrite`=1.
- beq: opcode=000100. With `Zero`=1, BRANCH shows `PCEn`=1, `PCSrc`=01, `alucontrol`=110. With `Zero`=0, `PCEn`=0. Toggling `Zero` in any non-BRANCH state leaves `PCEn` unchanged.
- j and illegal: opcode=000010 gives sequence 0,1,11,0 with `PCSrc`=10 and `PCEn`=1 in state 11. Opcode=111111 gives sequence 0,1,0 with `illegal_op`=1 in the DECODE cycle and `instr_done` never asserted.
- Reset mid-instruction: assert `reset` while in MEMRD of a lw. Required: next state is FETCH (0), with no `RegWrite` pulse and no `instr_done` pulse.
